// File: rtl/miriscv_imem_dmem_arbiter.sv
// miriscv_imem_dmem_arbiter
// Shares one memory port between the fetch unit and the LSU. Only one
// address phase is presented at a time, and at most MAX_OUTSTANDING
// transactions are in flight. Each response is routed to its requester
// through a small owner FIFO.
// Optional build macro: MIRISCV_ARB_ROUND_ROBIN_EN. When it is defined, a
// tie is won by the requester that was not granted last. Without it, data
// wins over fetch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no address phase held; arbitrate among the incoming requests
// WAIT_GNT | address phase presented for owner_q, waiting on mem_gnt_i

module miriscv_imem_dmem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o,
  output logic              proto_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_GNT = 1'b1;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       proto_err_q, proto_err_d;

  logic sel;
  logic mem_req;
  logic push;
  logic pop;
  logic full;
  logic head;
  logic tie_winner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // rr_q holds the last granted owner; a tie goes to the other requester
  always_comb begin
    tie_winner = ~rr_q;
    rr_d       = push ? sel : rr_q;
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rr_q <= OWN_INSTR;
    else          rr_q <= rr_d;
  end
`else
  assign tie_winner = OWN_DATA;
`endif

  assign full = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign head = fifo_q[rd_ptr_q];
  assign pop  = mem_rvalid_i && (count_q != '0);

  // Arbitration and address-phase FSM. The reset term keeps the memory
  // port quiet while arstn_i is low, even if requests are already high.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel     = owner_q;
    mem_req = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arstn_i && !full && (instr_req_i || data_req_i)) begin
          if (instr_req_i && data_req_i) sel = tie_winner;
          else                           sel = data_req_i ? OWN_DATA : OWN_INSTR;
          mem_req = 1'b1;
          if (mem_gnt_i) begin
            push = 1'b1;
          end else begin
            state_d = ST_WAIT_GNT;
            owner_d = sel;
          end
        end
      end
      ST_WAIT_GNT: begin
        // The request is held until it is granted. If the owner withdraws
        // its request, the FSM returns to IDLE and nothing is pushed.
        if (arstn_i && ((owner_q == OWN_DATA) ? data_req_i : instr_req_i)) begin
          mem_req = 1'b1;
          if (mem_gnt_i) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner FIFO, occupancy count and sticky protocol error next-state
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    proto_err_d = proto_err_q | (mem_rvalid_i && (count_q == '0));
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // State registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_INSTR;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // A fetch always presents a full-word read
  assign mem_req_o   = mem_req;
  assign mem_addr_o  = !mem_req ? '0 : (sel == OWN_DATA) ? data_addr_i : instr_addr_i;
  assign mem_we_o    = mem_req && (sel == OWN_DATA) && data_we_i;
  assign mem_be_o    = !mem_req ? '0 : (sel == OWN_DATA) ? data_be_i : '1;
  assign mem_wdata_o = (mem_req && (sel == OWN_DATA)) ? data_wdata_i : '0;

  assign instr_gnt_o    = push && (sel == OWN_INSTR);
  assign data_gnt_o     = push && (sel == OWN_DATA);
  assign instr_rvalid_o = pop && (head == OWN_INSTR);
  assign data_rvalid_o  = pop && (head == OWN_DATA);
  assign instr_rdata_o  = arstn_i ? mem_rdata_i : '0;
  assign data_rdata_o   = arstn_i ? mem_rdata_i : '0;

  assign busy_o      = (count_q != '0);
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_miriscv_imem_dmem_arbiter.sv
// Directed bench for miriscv_imem_dmem_arbiter (XLEN=32, MAX_OUTSTANDING=2).
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.

module tb_miriscv_imem_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, proto_err_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic data_first;

  miriscv_imem_dmem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    instr_req_i = 0; instr_addr_i = '0; data_req_i = 0; data_we_i = 0; data_be_i = '0;
    data_addr_i = '0; data_wdata_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    #12;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); else pass_cnt++;
    total_cnt++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) $display("FAIL rst_gnt got=%0h exp=0", {instr_gnt_o, data_gnt_o}); else pass_cnt++;
    total_cnt++; if (instr_rdata_o !== 32'h0) $display("FAIL rst_rdata got=%h exp=00000000", instr_rdata_o); else pass_cnt++;
    total_cnt++; if ({busy_o, proto_err_o} !== 2'b00) $display("FAIL rst_busy_err got=%0h exp=0", {busy_o, proto_err_o}); else pass_cnt++;
    next_cycle(); clear_inputs(); arstn_i = 1;
  endtask

  task automatic test_single_fetch();
    next_cycle(); instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) $display("FAIL sf_gnt got=%0h exp=2", {instr_gnt_o, data_gnt_o}); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) $display("FAIL sf_mem got=%h/%0h/%h exp=00000100/0/f", mem_addr_o, mem_we_o, mem_be_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13; #1;
    total_cnt++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL sf_rvalid got=%0h exp=2", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    total_cnt++; if (instr_rdata_o !== 32'h13) $display("FAIL sf_rdata got=%h exp=00000013", instr_rdata_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL sf_busy got=%0h exp=1", busy_o); else pass_cnt++;
    next_cycle(); clear_inputs(); #1;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL sf_idle got=%0h exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_contention();
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
    data_first = 1'b0;
`else
    data_first = 1'b1;
`endif
    // A lone data access makes data the most recently granted requester
    next_cycle(); data_req_i = 1; data_addr_i = 32'h3000; data_be_i = 4'hF; mem_gnt_i = 1; #1;
    total_cnt++; if (data_gnt_o !== 1'b1) $display("FAIL ct_pre_gnt got=%0h exp=1", data_gnt_o); else pass_cnt++;
    next_cycle(); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    total_cnt++; if (data_rvalid_o !== 1'b1) $display("FAIL ct_pre_rvalid got=%0h exp=1", data_rvalid_o); else pass_cnt++;
    next_cycle(); mem_rvalid_i = 0;
    data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h2000; data_wdata_i = 32'h55;
    instr_req_i = 1; instr_addr_i = 32'h104; mem_gnt_i = 1; #1;
    total_cnt++; if ({instr_gnt_o, data_gnt_o} !== {~data_first, data_first}) $display("FAIL ct_first_gnt got=%0h exp=%0h", {instr_gnt_o, data_gnt_o}, {~data_first, data_first}); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== (data_first ? 32'h2000 : 32'h104) || mem_we_o !== data_first) $display("FAIL ct_first_mem got=%h/%0h exp=%h/%0h", mem_addr_o, mem_we_o, data_first ? 32'h2000 : 32'h104, data_first); else pass_cnt++;
    next_cycle(); if (data_first) data_req_i = 0; else instr_req_i = 0; #1;
    total_cnt++; if ({instr_gnt_o, data_gnt_o} !== {data_first, ~data_first}) $display("FAIL ct_second_gnt got=%0h exp=%0h", {instr_gnt_o, data_gnt_o}, {data_first, ~data_first}); else pass_cnt++;
    total_cnt++; if (data_first && (mem_addr_o !== 32'h104 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0))
      $display("FAIL ct_fetch_fields got=%h/%0h/%h/%h exp=00000104/0/f/00000000", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
    else if (!data_first && (mem_addr_o !== 32'h2000 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'h55))
      $display("FAIL ct_data_fields got=%h/%0h/%h exp=00002000/1/00000055", mem_addr_o, mem_we_o, mem_wdata_o);
    else pass_cnt++;
    next_cycle(); instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== {~data_first, data_first}) $display("FAIL ct_rv1 got=%0h exp=%0h", {instr_rvalid_o, data_rvalid_o}, {~data_first, data_first}); else pass_cnt++;
    next_cycle(); #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== {data_first, ~data_first}) $display("FAIL ct_rv2 got=%0h exp=%0h", {instr_rvalid_o, data_rvalid_o}, {data_first, ~data_first}); else pass_cnt++;
    next_cycle(); clear_inputs(); #1;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL ct_idle got=%0h exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_stall();
    next_cycle(); data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h2000; mem_gnt_i = 0; #1;
    total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000 || data_gnt_o !== 1'b0) $display("FAIL st_c0 got=%0h/%h/%0h exp=1/00002000/0", mem_req_o, mem_addr_o, data_gnt_o); else pass_cnt++;
    next_cycle(); instr_req_i = 1; instr_addr_i = 32'h104; #1;
    total_cnt++; if (mem_addr_o !== 32'h2000 || instr_gnt_o !== 1'b0) $display("FAIL st_c1 got=%h/%0h exp=00002000/0", mem_addr_o, instr_gnt_o); else pass_cnt++;
    next_cycle(); #1;
    total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000 || instr_gnt_o !== 1'b0) $display("FAIL st_c2 got=%0h/%h/%0h exp=1/00002000/0", mem_req_o, mem_addr_o, instr_gnt_o); else pass_cnt++;
    next_cycle(); mem_gnt_i = 1; #1;
    total_cnt++; if ({instr_gnt_o, data_gnt_o} !== 2'b01 || mem_addr_o !== 32'h2000) $display("FAIL st_c3 got=%0h/%h exp=1/00002000", {instr_gnt_o, data_gnt_o}, mem_addr_o); else pass_cnt++;
    next_cycle(); data_req_i = 0; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h104) $display("FAIL st_instr got=%0h/%h exp=1/00000104", instr_gnt_o, mem_addr_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) $display("FAIL st_rv1 got=%0h exp=1", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    next_cycle(); #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) $display("FAIL st_rv2 got=%0h exp=2", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    next_cycle(); clear_inputs();
  endtask

  task automatic test_full();
    next_cycle(); instr_req_i = 1; instr_addr_i = 32'h200; mem_gnt_i = 1; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1) $display("FAIL fu_g1 got=%0h exp=1", instr_gnt_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h4000; data_be_i = 4'h3; #1;
    total_cnt++; if (data_gnt_o !== 1'b1 || mem_be_o !== 4'h3) $display("FAIL fu_g2 got=%0h/%h exp=1/3", data_gnt_o, mem_be_o); else pass_cnt++;
    next_cycle(); data_req_i = 0; instr_req_i = 1; #1;
    total_cnt++; if (mem_req_o !== 1'b0 || {instr_gnt_o, data_gnt_o} !== 2'b00 || busy_o !== 1'b1) $display("FAIL fu_block got=%0h/%0h/%0h exp=0/0/1", mem_req_o, {instr_gnt_o, data_gnt_o}, busy_o); else pass_cnt++;
    next_cycle(); mem_rvalid_i = 1; mem_rdata_i = 32'h77; #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'h77) $display("FAIL fu_pop got=%0h/%h exp=2/00000077", {instr_rvalid_o, data_rvalid_o}, instr_rdata_o); else pass_cnt++;
    total_cnt++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) $display("FAIL fu_pop_block got=%0h/%0h exp=0/0", mem_req_o, instr_gnt_o); else pass_cnt++;
    next_cycle(); mem_rvalid_i = 0; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h200) $display("FAIL fu_resume got=%0h/%h exp=1/00000200", instr_gnt_o, mem_addr_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) $display("FAIL fu_rv_data got=%0h exp=1", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    next_cycle(); #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) $display("FAIL fu_rv_instr got=%0h exp=2", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    next_cycle(); clear_inputs();
  endtask

  task automatic test_ordering();
    next_cycle(); instr_req_i = 1; instr_addr_i = 32'h300; mem_gnt_i = 1; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1) $display("FAIL or_g1 got=%0h exp=1", instr_gnt_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h5000; data_be_i = 4'hF;
    mem_rvalid_i = 1; mem_rdata_i = 32'hA; #1;
    total_cnt++; if (data_gnt_o !== 1'b1 || instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'hA)
      $display("FAIL or_c1 got=%0h/%0h/%0h/%h exp=1/1/0/0000000a", data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o); else pass_cnt++;
    next_cycle(); data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h304; mem_rdata_i = 32'hB; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1 || data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0 || data_rdata_o !== 32'hB)
      $display("FAIL or_c2 got=%0h/%0h/%0h/%h exp=1/1/0/0000000b", instr_gnt_o, data_rvalid_o, instr_rvalid_o, data_rdata_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hC; #1;
    total_cnt++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'hC || busy_o !== 1'b1)
      $display("FAIL or_c3 got=%0h/%0h/%h/%0h exp=1/0/0000000c/1", instr_rvalid_o, data_rvalid_o, instr_rdata_o, busy_o); else pass_cnt++;
    next_cycle(); clear_inputs(); #1;
    total_cnt++; if (busy_o !== 1'b0 || proto_err_o !== 1'b0) $display("FAIL or_done got=%0h/%0h exp=0/0", busy_o, proto_err_o); else pass_cnt++;
  endtask

  task automatic test_proto_err();
    next_cycle(); mem_rvalid_i = 1; mem_rdata_i = 32'h99; #1;
    total_cnt++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) $display("FAIL pe_rvalid got=%0h exp=0", {instr_rvalid_o, data_rvalid_o}); else pass_cnt++;
    next_cycle(); mem_rvalid_i = 0; #1;
    total_cnt++; if (proto_err_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL pe_set got=%0h/%0h exp=1/0", proto_err_o, busy_o); else pass_cnt++;
    next_cycle(); next_cycle(); #1;
    total_cnt++; if (proto_err_o !== 1'b1) $display("FAIL pe_hold got=%0h exp=1", proto_err_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    next_cycle(); data_req_i = 1; data_addr_i = 32'h6000; data_be_i = 4'hF; mem_gnt_i = 0;
    next_cycle(); #1;
    total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h6000) $display("FAIL ar_wait got=%0h/%h exp=1/00006000", mem_req_o, mem_addr_o); else pass_cnt++;
    #1; mem_gnt_i = 1; mem_rdata_i = 32'h1234; arstn_i = 0; #1;
    total_cnt++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || data_gnt_o !== 1'b0 || data_rdata_o !== 32'h0)
      $display("FAIL ar_outputs got=%0h/%h/%0h/%h exp=0/00000000/0/00000000", mem_req_o, mem_addr_o, data_gnt_o, data_rdata_o); else pass_cnt++;
    total_cnt++; if (proto_err_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL ar_regs got=%0h/%0h exp=0/0", proto_err_o, busy_o); else pass_cnt++;
    next_cycle(); clear_inputs(); arstn_i = 1;
    // A leftover WAIT_GNT state would still present the data address here
    next_cycle(); instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1; #1;
    total_cnt++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h400) $display("FAIL ar_idle got=%0h/%h exp=1/00000400", instr_gnt_o, mem_addr_o); else pass_cnt++;
    next_cycle(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    total_cnt++; if (instr_rvalid_o !== 1'b1) $display("FAIL ar_rv got=%0h exp=1", instr_rvalid_o); else pass_cnt++;
    next_cycle(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_stall();
    test_full();
    test_ordering();
    test_proto_err();
    test_async_reset();
    next_cycle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
